// File: rtl/spi_reg_master.sv
// SPI mode-0 master issuing single-register write/read frames to a 4-entry slave register bank.
// Optional read dummy phase enabled by defining SPI_REG_MASTER_DUMMY_EN.
module spi_reg_master #(
  parameter int unsigned REG_SIZE     = 8,
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned DUMMY_CYCLES = 4
) (
  input  logic                sclk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [1:0]          req_addr,
  input  logic [REG_SIZE-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [REG_SIZE-1:0] rsp_rdata,
  output logic                spi_clk,
  output logic                spi_cs_n,
  output logic                spi_mosi,
  input  logic                spi_miso
);

  localparam int unsigned CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned MAXBITS = (REG_SIZE > 8) ?
                                    ((REG_SIZE > DUMMY_CYCLES) ? REG_SIZE : DUMMY_CYCLES) :
                                    ((DUMMY_CYCLES > 8) ? DUMMY_CYCLES : 8);
  localparam int unsigned BW      = $clog2(MAXBITS);
  localparam int unsigned SW      = 8 + REG_SIZE;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CMD, S_DUMMY, S_DATA, S_HOLD, S_GAP
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic                r_half, w_half_nxt;
  logic [BW-1:0]       r_bit, w_bit_nxt;
  logic [SW-1:0]       r_sh, w_sh_nxt;
  logic [REG_SIZE-1:0] r_rx, w_rx_nxt;
  logic                r_wr, w_wr_nxt;
  logic                r_clk, w_clk_nxt;
  logic                r_cs_n, w_cs_n_nxt;
  logic                r_mosi, w_mosi_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [REG_SIZE-1:0] r_rdata, w_rdata_nxt;
  logic                w_tick;
  logic                w_last;

  assign w_tick = (r_cnt == CW'(CLK_DIV - 1));

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      S_CMD:   w_last = (r_bit == BW'(7));
      S_DUMMY: w_last = (r_bit == BW'(DUMMY_CYCLES - 1));
      S_DATA:  w_last = (r_bit == BW'(REG_SIZE - 1));
      default: w_last = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = w_tick ? '0 : r_cnt + CW'(1);
    w_half_nxt      = r_half;
    w_bit_nxt       = r_bit;
    w_sh_nxt        = r_sh;
    w_rx_nxt        = r_rx;
    w_wr_nxt        = r_wr;
    w_clk_nxt       = r_clk;
    w_cs_n_nxt      = r_cs_n;
    w_mosi_nxt      = r_mosi;
    w_rsp_valid_nxt = 1'b0;
    w_rdata_nxt     = r_rdata;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (req_valid) begin
          w_state_nxt = S_SETUP;
          w_cs_n_nxt  = 1'b0;
          w_clk_nxt   = 1'b0;
          w_mosi_nxt  = 1'b0;
          w_wr_nxt    = req_wr;
          w_sh_nxt    = {req_wr, 5'b00000, req_addr, req_wdata & {REG_SIZE{req_wr}}};
        end
      end
      S_SETUP: begin
        if (w_tick) begin
          w_state_nxt = S_CMD;
          w_mosi_nxt  = r_sh[SW-1];
          w_half_nxt  = 1'b0;
          w_bit_nxt   = '0;
        end
      end
      S_CMD, S_DUMMY, S_DATA: begin
        if (w_tick) begin
          if (!r_half) begin
            w_clk_nxt  = 1'b1;
            w_half_nxt = 1'b1;
            if (r_state == S_DATA && !r_wr) begin
              w_rx_nxt = REG_SIZE'({r_rx, spi_miso});
            end
          end else begin
            // Falling half: the next bit goes onto mosi as spi_clk drops.
            w_clk_nxt  = 1'b0;
            w_half_nxt = 1'b0;
            if (!w_last) begin
              w_bit_nxt = r_bit + BW'(1);
              if (r_state != S_DUMMY) begin
                w_sh_nxt   = {r_sh[SW-2:0], 1'b0};
                w_mosi_nxt = r_sh[SW-2];
              end
            end else begin
              w_bit_nxt = '0;
              case (r_state)
                S_CMD: begin
                  w_sh_nxt    = {r_sh[SW-2:0], 1'b0};
                  w_mosi_nxt  = r_sh[SW-2];
                  w_state_nxt = S_DATA;
`ifdef SPI_REG_MASTER_DUMMY_EN
                  if (!r_wr) begin
                    w_state_nxt = S_DUMMY;
                    w_mosi_nxt  = 1'b0;
                  end
`endif
                end
                S_DUMMY: begin
                  w_state_nxt = S_DATA;
                  w_mosi_nxt  = r_sh[SW-1];
                end
                default: begin
                  w_state_nxt = S_HOLD;
                  w_mosi_nxt  = 1'b0;
                end
              endcase
            end
          end
        end
      end
      S_HOLD: begin
        if (w_tick) begin
          w_cs_n_nxt      = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          if (!r_wr) begin
            w_rdata_nxt = r_rx;
          end
          // The IDLE cycle counts toward chip-select high time, so GAP is one cycle short.
          w_state_nxt = (CLK_DIV == 1) ? S_IDLE : S_GAP;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_GAP: begin
        if (w_tick) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_half      <= 1'b0;
      r_bit       <= '0;
      r_sh        <= '0;
      r_rx        <= '0;
      r_wr        <= 1'b0;
      r_clk       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_half      <= w_half_nxt;
      r_bit       <= w_bit_nxt;
      r_sh        <= w_sh_nxt;
      r_rx        <= w_rx_nxt;
      r_wr        <= w_wr_nxt;
      r_clk       <= w_clk_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_mosi      <= w_mosi_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign spi_clk   = r_clk;
  assign spi_cs_n  = r_cs_n;
  assign spi_mosi  = r_mosi;

endmodule
